dma_rd_collector: RTL
=====================

Name: dma_rd_collector

Overview:
- Downstream consumer of the DMA AXI read-address issuer; owns the AXI read-data (R) channel for one outstanding burst.
- Issuer hands over ID and ARLEN when AR is accepted; this block accepts R beats and checks RID, RRESP and RLAST against that command.
- Accepted beats are buffered in a small first-word-fall-through FIFO that feeds the DMA write side.
- Sticky error status is reported to the channel controller.

Parameters:
- DATA_W, 32, R data width
- ID_W, 4, AXI ID width
- LEN_W, 4, burst length field width (beats = len+1)
- DEPTH, 8, FIFO entries; power of two, >=2
- TIMEOUT_CYC, 255, idle-beat watchdog limit; used only with the optional feature

Ports:
- clks.clk  in  1  clock; all logic on rising edge
- clks.rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  burst command from address issuer
- cmd_ready  out  1  collector can take a command
- cmd_id  in  ID_W  expected RID
- cmd_len  in  LEN_W  ARLEN of the burst
- rid  in  ID_W  AXI RID
- rdata  in  DATA_W  AXI RDATA
- rresp  in  2  AXI RRESP
- rlast  in  1  AXI RLAST
- rvalid  in  1  AXI RVALID
- rready  out  1  AXI RREADY
- out_data  out  DATA_W  FIFO head data
- out_last  out  1  head is final beat of its burst
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pops head
- done  out  1  one-cycle pulse, burst terminated
- busy  out  1  state is RECV
- err_id  out  1  sticky RID mismatch
- err_resp  out  1  sticky SLVERR/DECERR
- err_last  out  1  sticky RLAST misplacement
- err_timeout  out  1  sticky watchdog expiry
- err_clr  in  1  clears all sticky errors

Behaviour:
- Reset (async, clks.rst=1): state IDLE, FIFO flushed.
- Reset values: cmd_ready=1, rready=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0, all err_*=0, beat counter=0.
- Reset asserted mid-burst abandons the burst; no done pulse is generated.
- State machine has two states, IDLE and RECV.
- IDLE: cmd_ready=1.
  - cmd_valid=1: latch cmd_id and cmd_len, clear beat counter, go to RECV next cycle.
- RECV: cmd_ready=0, busy=1, rready = !full, where full is the registered FIFO count == DEPTH.
  - A pop in the same cycle does not raise rready.
- Beat accept: rvalid && rready. Push {rdata, is_final} and increment the counter.
  - is_final = (counter == latched_len) || rlast.
- Checks, per accepted beat:
  - rid != latched id -> err_id.
  - rresp == 2'b10 or 2'b11 -> err_resp. 2'b00 and 2'b01 are OK.
  - rlast=1 with counter < len, or rlast=0 with counter == len -> err_last.
- Termination: on the beat with counter == len, or on a premature rlast, pulse done the following cycle and return to IDLE.
  - The next command can be accepted in the cycle after done.
  - Beats are never dropped. Errored beats are still pushed.
- Counter is LEN_W+1 bits wide and cannot wrap within a legal burst.
- FIFO is first-word-fall-through.
  - A beat accepted in cycle N shows out_valid=1 in cycle N+1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop when empty is ignored.
  - When empty, out_data and out_last hold their last value, don't-care to the consumer.
- Sticky errors: set on detection, cleared by err_clr.
  - err_clr and a new error in the same cycle -> the error remains set.
- rvalid while IDLE: rready=0; beat not accepted, no error.

Optional Feature:
- Macro DMA_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on each accepted beat and on entry to RECV, and increments each RECV cycle without a beat.
  - When it reaches TIMEOUT_CYC: set err_timeout, pulse done, return to IDLE. FIFO contents are kept.
  - A beat accepted in the same cycle as expiry takes priority; no timeout.
- Undefined: no watchdog logic; err_timeout tied to 0.

Test Plan:
- Normal burst: cmd_len=3, id=5; 4 beats 0xA0..0xA3 with rlast on the 4th, out_ready=1 -> 4 pops in order, out_last only on 0xA3, done pulses once, all err_*=0.
- Backpressure: cmd_len=15, out_ready=0 -> rready drops after 8 accepts (DEPTH=8).
  - Then out_ready=1 -> all 16 beats delivered in order with none lost, done after the 16th accept.
- Errors: beat 1 of a len=3 burst has rid=6 (expected 5) and rresp=2'b10 -> err_id=1, err_resp=1, data still delivered.
  - Then err_clr -> both errors clear.
- Premature rlast: cmd_len=7, rlast on beat 3 -> err_last=1, done after beat 3, out_last on beat 3, 3 entries in FIFO.
  - Missing rlast on beat 8 of a len=7 burst -> err_last=1 and normal termination.
- Reset: assert clks.rst after 2 of 4 beats -> immediately rready=0, out_valid=0, cmd_ready=1, no done pulse.
  - Next burst runs cleanly.
- DMA_RD_TIMEOUT_EN, TIMEOUT_CYC=10: cmd_len=3, one beat then rvalid=0 for 10 cycles -> err_timeout=1, done pulse, IDLE, 1 entry still in FIFO.

Source files
------------

// File: rtl/dma_rd_collector_if.sv
// Bundle of the collector's command, AXI R-channel, output-stream and status
// signals. The collector uses the slave modport; its environment uses master.
interface dma_rd_collector_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  // Command from the address issuer
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic [LEN_W-1:0]  cmd_len;
  // AXI read-data channel
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  // FIFO output towards the write side
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  // Status to the channel controller
  logic              done;
  logic              busy;
  logic              err_id;
  logic              err_resp;
  logic              err_last;
  logic              err_timeout;
  logic              err_clr;

  modport master (
    output cmd_valid, cmd_id, cmd_len, rid, rdata, rresp, rlast, rvalid,
           out_ready, err_clr,
    input  cmd_ready, rready, out_data, out_last, out_valid, done, busy,
           err_id, err_resp, err_last, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_len, rid, rdata, rresp, rlast, rvalid,
           out_ready, err_clr,
    output cmd_ready, rready, out_data, out_last, out_valid, done, busy,
           err_id, err_resp, err_last, err_timeout
  );
endinterface

// File: rtl/dma_rd_collector.sv
// AXI read-data collector for one outstanding DMA burst.
// Checks RID/RRESP/RLAST against the latched command, buffers beats in a
// first-word-fall-through FIFO and reports sticky errors.
// Optional idle-beat watchdog: define DMA_RD_TIMEOUT_EN.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   S_IDLE | waiting for a burst command, R channel not ready
//   S_RECV | accepting R beats of the latched burst
module dma_rd_collector #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int LEN_W       = 4,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  dma_rd_collector_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {S_IDLE, S_RECV} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W:0]    r_cnt;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_done;
  logic              r_err_id;
  logic              r_err_resp;
  logic              r_err_last;

  logic w_full;
  logic w_rready;
  logic w_acc;
  logic w_pop;
  logic w_at_len;
  logic w_final;
  logic w_term;
  logic w_timeout;
  logic w_latch;
  logic w_cmd_ready;
  logic w_busy;

  // The full flag comes from the registered count, so a pop in the same
  // cycle cannot raise rready; this keeps rready free of out_ready paths.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_rready = (r_state == S_RECV) && !w_full;
  assign w_acc    = bus.rvalid && w_rready;
  assign w_pop    = (r_count != '0) && bus.out_ready;
  assign w_at_len = (r_cnt == {1'b0, r_len});
  assign w_final  = w_at_len || bus.rlast;
  assign w_term   = w_acc && w_final;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_busy      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_latch = 1'b1;
          w_next  = S_RECV;
        end
      end
      S_RECV: begin
        w_busy = 1'b1;
        if (w_term || w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id  <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_latch) begin
      r_id  <= bus.cmd_id;
      r_len <= bus.cmd_len;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy; errored beats are pushed too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc) begin
        r_mem[r_wr_ptr] <= {w_final, bus.rdata};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Done pulse and sticky errors; a new error wins over err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_err_id   <= 1'b0;
      r_err_resp <= 1'b0;
      r_err_last <= 1'b0;
    end else begin
      r_done     <= w_term || w_timeout;
      r_err_id   <= (r_err_id && !bus.err_clr) || (w_acc && (bus.rid != r_id));
      r_err_resp <= (r_err_resp && !bus.err_clr) || (w_acc && bus.rresp[1]);
      r_err_last <= (r_err_last && !bus.err_clr) ||
                    (w_acc && (bus.rlast != w_at_len));
    end
  end

`ifdef DMA_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err_to;

  // Expires on the TIMEOUT_CYC-th consecutive RECV cycle without a beat
  assign w_timeout = (r_state == S_RECV) && !w_acc &&
                     (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counter, restarted on burst entry and on every beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_wdog <= '0;
    else if (w_latch || w_acc) r_wdog <= '0;
    else if (r_state == S_RECV) r_wdog <= r_wdog + WD_W'(1);
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_to <= 1'b0;
    else     r_err_to <= (r_err_to && !bus.err_clr) || w_timeout;
  end

  assign bus.err_timeout = r_err_to;
`else
  assign w_timeout       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.busy      = w_busy;
  assign bus.rready    = w_rready;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr][DATA_W-1:0];
  assign bus.out_last  = r_mem[r_rd_ptr][DATA_W];
  assign bus.done      = r_done;
  assign bus.err_id    = r_err_id;
  assign bus.err_resp  = r_err_resp;
  assign bus.err_last  = r_err_last;

endmodule
